// File: rtl/tx_frame_scheduler_if.sv
// Requester and serializer signals of the shared IrDA byte transmitter.
interface tx_frame_scheduler_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        tx_send_en;
  logic [7:0]  tx_din;
  logic        tx_busy;
  logic        err_timeout;

  // Scheduler side
  modport master (
    input  req, req_data, tx_busy,
    output ack, grant_id, sched_busy, tx_send_en, tx_din, err_timeout
  );

  // Requesters plus serializer side
  modport slave (
    output req, req_data, tx_busy,
    input  ack, grant_id, sched_busy, tx_send_en, tx_din, err_timeout
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler feeding 2-byte frames (header, data) from 4 requesters
// into one byte serializer, with a start timeout that drops the frame.
module tx_frame_scheduler #(
  parameter logic [3:0]  HDR_TAG       = 4'hA,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic                  CLK_50M,
  input logic                  reset_n,
  tx_frame_scheduler_if.master bus
);
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t            state;
  logic              phase_dat;
  logic [ID_W-1:0]   ptr;
  logic [7:0]        data_reg;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   winner_c;
  logic [7:0]        req_byte_c;

  // Round-robin pick: nearest set request after ptr, wrapping; scanned far-to-near
  always_comb begin
    winner_c = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req[ptr + ID_W'(i)]) winner_c = ptr + ID_W'(i);
    end
    req_byte_c = bus.req_data[{winner_c, 3'b000} +: 8];
  end

  // Frame sequencer: grant, header/data sends, serializer handshake, timeout
  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      state           <= IDLE;
      phase_dat       <= 1'b0;
      ptr             <= ID_W'(N_REQ - 1);
      data_reg        <= '0;
      cnt             <= '0;
      bus.ack         <= '0;
      bus.grant_id    <= '0;
      bus.sched_busy  <= 1'b0;
      bus.tx_send_en  <= 1'b0;
      bus.tx_din      <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.ack         <= '0;
      bus.tx_send_en  <= 1'b0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.ack[winner_c] <= 1'b1;
            bus.grant_id      <= winner_c;
            ptr               <= winner_c;
            data_reg          <= req_byte_c;
            bus.sched_busy    <= 1'b1;
            phase_dat         <= 1'b0;
            state             <= SEND;
          end
        end
        SEND: begin
          bus.tx_send_en <= 1'b1;
          bus.tx_din     <= phase_dat ? data_reg : {HDR_TAG, 2'b00, bus.grant_id};
          cnt            <= '0;
          state          <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= WAIT_LO;
          end else if (cnt == TOUT_LAST) begin
            bus.err_timeout <= 1'b1;
            bus.sched_busy  <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (!phase_dat) begin
              phase_dat <= 1'b1;
              state     <= SEND;
            end else begin
              bus.sched_busy <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Shares the single IrDA byte serializer (send_en/Din/busy handshake, 50 MHz domain) between 4 requesters.
- Requesters are selected by round-robin arbitration.
- For each grant it sends a 2-byte frame: a header byte tagging the source channel, then the requester's data byte.
- It sequences the serializer handshake and drops the frame if the serializer never starts.

Parameters:
- HDR_TAG, 4'hA, upper nibble of every header byte.
- START_TIMEOUT, 16, max cycles from send_en pulse to tx_busy rising before abort (legal range 2..255).

Ports:
- CLK_50M  in  1  system clock, 50 MHz, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req  in  4  req[i]=1: requester i has a byte pending.
- req_data  in  32  byte of requester i on [8i+7:8i]; sampled only in the grant cycle.
- ack  out  4  one-cycle pulse on bit i when requester i's byte is latched; requester may drop req/change data next cycle.
- grant_id  out  2  channel of the frame in progress; holds its last value when idle.
- sched_busy  out  1  high from grant until frame completes or aborts.
- tx_send_en  out  1  one-cycle start pulse to the serializer.
- tx_din  out  8  byte to the serializer.
- tx_busy  in  1  serializer busy.
- err_timeout  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Clock and reset: one clock, CLK_50M. Reset is synchronous and active-low on reset_n: sampled only on the CLK_50M rising edge, with priority over all else.
- Reset values: ack=0, grant_id=0, sched_busy=0, tx_send_en=0, tx_din=8'h00, err_timeout=0, rr pointer=3 (so channel 0 wins first), state=IDLE. Reset mid-frame aborts immediately without an err_timeout pulse.
- States: IDLE, SEND, WAIT_HI, WAIT_LO. A phase bit selects HDR or DAT.
- IDLE, when req!=0 at edge k:
  - Winner = first set bit searching from (ptr+1) mod 4 upward, wrapping.
  - At edge k: ack[winner]=1 for exactly one cycle, grant_id=winner, ptr=winner, data_reg=req_data byte, sched_busy=1, phase=HDR, go to SEND.
- SEND (one cycle): drive tx_send_en=1 and tx_din = header {HDR_TAG,2'b00,grant_id} or data_reg. Clear the timeout counter. Go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Counter reaches START_TIMEOUT cycles (counted from the cycle after the SEND pulse) with busy never seen: err_timeout pulses for one cycle, sched_busy=0, go to IDLE. The frame is dropped (no retry) and ptr still advances.
- WAIT_LO:
  - tx_busy=0 with phase=HDR: phase=DAT, go to SEND.
  - tx_busy=0 with phase=DAT: sched_busy=0, go to IDLE.
  - No timeout in this state.
- tx_din is held stable from SEND through WAIT_LO. It retains the last byte in IDLE.
- tx_send_en is never high outside SEND, so it is never asserted while tx_busy=1.
- Latency: grant edge k, header send_en at cycle k+1.
- Gaps:
  - One SEND cycle after busy falls before the data byte starts.
  - After a frame ends, the next grant occurs at the first IDLE cycle, at the earliest 1 cycle after the frame ends.
- req changes while sched_busy=1 are ignored. New requests wait; there is no queueing beyond each requester's own req level.
- If req[i] is still high after a frame completes, it is treated as a new byte.
- Simultaneous requests: strict round-robin; each requester gets at most one frame per rotation while others are pending.

Test Plan:
- Single request: reset 5 cycles, req=4'b0001, req_data[7:0]=8'hAC; model serializer busy=1 for 10 cycles starting 2 cycles after send_en -> ack=0001 one cycle, tx_din=8'hA0 then 8'hAC, exactly two send_en pulses, sched_busy low after second busy fall.
- Round-robin: req=4'b1111 held, bytes 11/22/33/44 -> data order 11,22,33,44,11; headers A0,A1,A2,A3,A0; each ack a single pulse.
- Wrap/skip: after channel 2 served, req=4'b0011 -> channel 0 granted next (header A0), then channel 1 (A1); channel 3 is not granted.
- Timeout: serializer never raises busy -> err_timeout pulses exactly START_TIMEOUT(16) cycles after the header send_en, no data byte sent, sched_busy=0, next req=4'b0010 granted normally.
- Reset mid-frame: reset_n=0 for 1 cycle during WAIT_LO of the data byte -> all outputs return to reset values next edge, no err_timeout, first subsequent grant goes to channel 0.
- Stability: change req_data and drop req one cycle after ack -> transmitted data byte equals the value latched at ack; tx_din constant while tx_busy=1.
